// File: rtl/bsg_cover_sink.sv
// Coverage drain arbiter: picks one gated or swept channel round-robin and
// streams its packet (header, data beats, beat-count trailer) onto one output.

module bsg_cover_sink_lane (
  input  logic sel_i,
  input  logic drain_en_i,
  input  logic ready_en_i,
  output logic drain_o,
  output logic ready_o
);
  assign drain_o = sel_i & drain_en_i;
  assign ready_o = sel_i & ready_en_i;
endmodule

module bsg_cover_sink #(
  parameter int num_p       = 4,
  parameter int out_width_p = 64,
  parameter int id_width_p  = 8,
  parameter int els_width_p = 16,
  parameter int len_width_p = 8,
  parameter int cnt_width_p = 32
) (
  input  logic                           clk_i,
  input  logic                           reset_n_i,
  input  logic                           drain_all_i,
  input  logic [num_p-1:0]               gate_i,
  output logic [num_p-1:0]               drain_o,
  input  logic [num_p-1:0]               id_v_i,
  input  logic [num_p*id_width_p-1:0]    id_i,
  input  logic [num_p*els_width_p-1:0]   els_i,
  input  logic [num_p*len_width_p-1:0]   len_i,
  input  logic [num_p-1:0]               v_i,
  input  logic [num_p-1:0]               last_i,
  input  logic [num_p*out_width_p-1:0]   data_i,
  output logic [num_p-1:0]               ready_o,
  output logic                           v_o,
  input  logic                           ready_i,
  output logic [out_width_p-1:0]         data_o,
  output logic                           last_o,
  output logic                           sweep_busy_o,
  output logic                           err_o
);
  localparam int PW = (num_p > 1) ? $clog2(num_p) : 1;
  localparam int HW = id_width_p + els_width_p + len_width_p;

  typedef enum logic [2:0] {IDLE, REQ, HDR, DATA, TRL} state_e;

  state_e                 state_q, state_d;
  logic [PW-1:0]          ch_r, ch_d, ptr_q, ptr_d, sel;
  logic [num_p-1:0]       mask_q, mask_d, cand;
  logic [id_width_p-1:0]  id_q, id_d;
  logic [els_width_p-1:0] els_q, els_d;
  logic [len_width_p-1:0] len_q, len_d;
  logic [cnt_width_p-1:0] cnt_q, cnt_d;
  logic                   err_q, err_d;
  logic                   found, drain_en, ready_en;
  int                     idx;

  logic [id_width_p-1:0]  id_a   [num_p];
  logic [els_width_p-1:0] els_a  [num_p];
  logic [len_width_p-1:0] len_a  [num_p];
  logic [out_width_p-1:0] data_a [num_p];

  for (genvar g = 0; g < num_p; g++) begin : g_lane
    assign id_a[g]   = id_i[g*id_width_p +: id_width_p];
    assign els_a[g]  = els_i[g*els_width_p +: els_width_p];
    assign len_a[g]  = len_i[g*len_width_p +: len_width_p];
    assign data_a[g] = data_i[g*out_width_p +: out_width_p];

    bsg_cover_sink_lane u_lane (
      .sel_i      (ch_r == PW'(g)),
      .drain_en_i (drain_en),
      .ready_en_i (ready_en),
      .drain_o    (drain_o[g]),
      .ready_o    (ready_o[g])
    );
  end

  assign cand         = gate_i | mask_q;
  assign sweep_busy_o = |mask_q;
  assign err_o        = err_q;

  // Round-robin: first candidate at or above ptr_q, wrapping past num_p-1.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < num_p; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= num_p) idx = idx - num_p;
      if (!found && cand[idx[PW-1:0]]) begin
        found = 1'b1;
        sel   = idx[PW-1:0];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    ch_d     = ch_r;
    ptr_d    = ptr_q;
    mask_d   = mask_q;
    id_d     = id_q;
    els_d    = els_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    v_o      = 1'b0;
    data_o   = '0;
    last_o   = 1'b0;
    drain_en = 1'b0;
    ready_en = 1'b0;
    case (state_q)
      IDLE: if (found) begin
        ch_d    = sel;
        state_d = REQ;
      end
      REQ: begin
        drain_en = 1'b1;
        ready_en = id_v_i[ch_r];
        if (id_v_i[ch_r]) begin
          id_d    = id_a[ch_r];
          els_d   = els_a[ch_r];
          len_d   = len_a[ch_r];
          state_d = HDR;
        end
      end
      HDR: begin
        v_o    = 1'b1;
        data_o = out_width_p'({len_q, els_q, id_q});
        if (ready_i) begin
          cnt_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        drain_en = 1'b1;
        ready_en = ready_i;
        v_o      = v_i[ch_r];
        data_o   = data_a[ch_r];
        if (v_i[ch_r] && ready_i) begin
          if (&cnt_q) err_d = 1'b1;
          else        cnt_d = cnt_q + 1'b1;
          if (last_i[ch_r]) state_d = TRL;
        end else if (!gate_i[ch_r] && !v_i[ch_r]) begin
          // channel went back to fill with nothing pending: close the packet
          state_d = TRL;
        end
      end
      TRL: begin
        v_o    = 1'b1;
        last_o = 1'b1;
        data_o = out_width_p'(cnt_q);
        if (ready_i) begin
          mask_d[ch_r] = 1'b0;
          ptr_d        = (int'(ch_r) == num_p - 1) ? '0 : ch_r + 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (drain_all_i) mask_d = '1;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      ch_r    <= '0;
      ptr_q   <= '0;
      mask_q  <= '0;
      id_q    <= '0;
      els_q   <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_r    <= ch_d;
      ptr_q   <= ptr_d;
      mask_q  <= mask_d;
      id_q    <= id_d;
      els_q   <= els_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  if (HW > out_width_p) begin : g_bad_hdr
    $error("header fields wider than out_width_p");
  end
  if (cnt_width_p > out_width_p) begin : g_bad_cnt
    $error("cnt_width_p wider than out_width_p");
  end
endmodule
